// File: rtl/pc_fetch_unit.sv
// PC holder and handshaked instruction fetch: IDLE -> REQ -> HOLD -> REQ ...
// Define PC_FETCH_FAULT_CHECK_EN to enable PC alignment/range checking with a sticky S_FAULT state.
module pc_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      npc,
  input  logic             npc_load,
  output logic [31:0]      pc,
  output logic             im_req,
  output logic [IM_AW-1:0] im_addr,
  input  logic             im_ack,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      fetch_cnt,
  output logic             fetch_fault
);

`ifdef PC_FETCH_FAULT_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [32:0] IM_SPAN = 33'd1 << (IM_AW + 2);

  // Misaligned, below the IM window, or beyond its end.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [31:0] off;
    off      = addr - IM_BASE;
    addr_bad = (addr[1:0] != 2'b00) || (addr < IM_BASE) || ({1'b0, off} >= IM_SPAN);
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        borrow_s;

  // Word index of (pc - IM_BASE): only bits [IM_AW+1:2] are needed, plus the borrow from bits [1:0].
  assign borrow_s = (pc_q[1:0] < IM_BASE[1:0]);
  assign im_addr  = pc_q[IM_AW+1:2] - IM_BASE[IM_AW+1:2] - {{(IM_AW-1){1'b0}}, borrow_s};
  assign im_req   = (state_q == S_REQ);

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_cnt   = fetch_cnt_q;

`ifdef PC_FETCH_FAULT_CHECK_EN
  logic fetch_fault_q, fetch_fault_d;
  assign fetch_fault = fetch_fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Next-state and register-update logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
`ifdef PC_FETCH_FAULT_CHECK_EN
    fetch_fault_d = fetch_fault_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef PC_FETCH_FAULT_CHECK_EN
        if (addr_bad(PC_RESET)) begin
          state_d       = S_FAULT;
          fetch_fault_d = 1'b1;
        end else begin
          state_d = S_REQ;
        end
`else
        state_d = S_REQ;
`endif
      end
      S_REQ: begin
        if (im_ack) begin
          instr_d       = im_rdata;
          instr_valid_d = 1'b1;
          fetch_cnt_d   = fetch_cnt_q + 32'd1;
          state_d       = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (npc_load) begin
          pc_d          = npc;
          instr_valid_d = 1'b0;
`ifdef PC_FETCH_FAULT_CHECK_EN
          if (addr_bad(npc)) begin
            instr_d       = 32'd0;
            fetch_fault_d = 1'b1;
            state_d       = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end else begin
          state_d = S_HOLD;
        end
      end
`ifdef PC_FETCH_FAULT_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_RESET;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      fetch_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

`ifdef PC_FETCH_FAULT_CHECK_EN
  // Sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_fault_q <= fetch_fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle behavioural model plus directed literal checks.
module tb_pc_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_AW    = 12;

  logic             clk;
  logic             rst_n;
  logic [31:0]      npc;
  logic             npc_load;
  logic [31:0]      pc;
  logic             im_req;
  logic [IM_AW-1:0] im_addr;
  logic             im_ack;
  logic [31:0]      im_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [31:0]      fetch_cnt;
  logic             fetch_fault;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_AW(IM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .npc_load(npc_load), .pc(pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .instr(instr), .instr_valid(instr_valid), .fetch_cnt(fetch_cnt), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  function automatic logic [31:0] a2w(input logic [IM_AW-1:0] a);
    return {{(32-IM_AW){1'b0}}, a};
  endfunction

  // ---------------- behavioural model ----------------
  // The unit is either waiting out its post-reset cycle, fetching (no valid instr),
  // holding a valid instr, or dead after a fault.
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_started, m_have, m_fault;

`ifdef PC_FETCH_FAULT_CHECK_EN
  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a < IM_BASE) || ((a - IM_BASE) >= 32'h0000_4000);
  endfunction
`endif

  function automatic logic [31:0] word_index(input logic [31:0] p);
    return ((p - IM_BASE) / 32'd4) % 32'd4096;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= PC_RESET; m_instr <= 32'd0; m_cnt <= 32'd0;
      m_started <= 1'b0; m_have <= 1'b0; m_fault <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
`ifdef PC_FETCH_FAULT_CHECK_EN
      if (bad_addr(PC_RESET)) m_fault <= 1'b1;
`endif
    end else if (m_fault) begin
      m_fault <= 1'b1;
    end else if (!m_have) begin
      if (im_ack) begin
        m_instr <= im_rdata;
        m_have  <= 1'b1;
        m_cnt   <= m_cnt + 32'd1;
      end
    end else if (npc_load) begin
      m_pc   <= npc;
      m_have <= 1'b0;
`ifdef PC_FETCH_FAULT_CHECK_EN
      if (bad_addr(npc)) begin
        m_instr <= 32'd0;
        m_fault <= 1'b1;
      end
`endif
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_started && !m_have && !m_fault;
    chk("m_pc", pc, m_pc);
    chk("m_im_req", b2w(im_req), b2w(exp_req));
    if (exp_req) chk("m_im_addr", a2w(im_addr), word_index(m_pc));
    chk("m_instr", instr, m_instr);
    chk("m_valid", b2w(instr_valid), b2w(m_have));
    chk("m_fetch_cnt", fetch_cnt, m_cnt);
    chk("m_fault", b2w(fetch_fault), b2w(m_fault));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load npc in S_HOLD and land in the first cycle after the load edge.
  task automatic load(input logic [31:0] v);
    npc = v; npc_load = 1'b1;
    step();
    npc_load = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; npc = 32'd0; npc_load = 1'b0; im_ack = 1'b0; im_rdata = 32'd0;
    repeat (3) step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_req", b2w(im_req), 32'd0);
    chk("rst_valid", b2w(instr_valid), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_fault", b2w(fetch_fault), 32'd0);

    // Zero-wait first fetch; ack held high already during the idle cycle.
    im_ack = 1'b1; im_rdata = 32'h2408_0001; rst_n = 1'b1;
    #1 chk("idle_req", b2w(im_req), 32'd0);
    step();
    chk("req1_req", b2w(im_req), 32'd1);
    chk("req1_addr", a2w(im_addr), 32'd0);
    step();
    chk("f1_instr", instr, 32'h2408_0001);
    chk("f1_valid", b2w(instr_valid), 32'd1);
    chk("f1_cnt", fetch_cnt, 32'd1);
    chk("f1_pc", pc, 32'h0000_3000);

    // Sequential stream of five zero-wait fetches.
    for (int i = 1; i <= 5; i++) begin
      load(32'h0000_3000 + 32'd4 * i);
      im_rdata = 32'h1000_0000 + i;
      chk("seq_addr", a2w(im_addr), i);
      chk("seq_valid_low", b2w(instr_valid), 32'd0);
      step();
      chk("seq_instr", instr, 32'h1000_0000 + i);
    end
    chk("seq_pc", pc, 32'h0000_3014);
    chk("seq_cnt", fetch_cnt, 32'd6);

    // Three wait states.
    im_ack = 1'b0;
    load(32'h0000_3018);
    for (int k = 0; k < 4; k++) begin
      chk("ws_req", b2w(im_req), 32'd1);
      chk("ws_addr", a2w(im_addr), 32'd6);
      chk("ws_valid_low", b2w(instr_valid), 32'd0);
      if (k == 3) begin
        im_ack = 1'b1; im_rdata = 32'hAAAA_0006;
      end
      step();
    end
    chk("ws_valid", b2w(instr_valid), 32'd1);
    chk("ws_instr", instr, 32'hAAAA_0006);
    chk("ws_cnt", fetch_cnt, 32'd7);
    im_ack = 1'b0;

    // Branch target, with a stray npc_load during S_REQ.
    load(32'h0000_3100);
    chk("br_pc", pc, 32'h0000_3100);
    chk("br_addr", a2w(im_addr), 32'h40);
    load(32'h0000_5000);
    chk("br_ignore_pc", pc, 32'h0000_3100);
    chk("br_still_req", b2w(im_req), 32'd1);
    im_ack = 1'b1; im_rdata = 32'hBBBB_0040;
    step();
    chk("br_cnt", fetch_cnt, 32'd8);
    chk("br_instr", instr, 32'hBBBB_0040);
    im_ack = 1'b0;

    // Async reset in the middle of a fetch.
    load(32'h0000_3200);
    chk("mid_req", b2w(im_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", b2w(im_req), 32'd0);
    chk("mid_rst_pc", pc, 32'h0000_3000);
    chk("mid_rst_cnt", fetch_cnt, 32'd0);
    chk("mid_rst_valid", b2w(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    step();
    rst_n = 1'b1; im_ack = 1'b1; im_rdata = 32'hCCCC_0000;
    step();
    chk("restart_addr", a2w(im_addr), 32'd0);
    step();
    chk("restart_cnt", fetch_cnt, 32'd1);
    im_ack = 1'b0;

    // Misaligned npc.
    load(32'h0000_3102);
    chk("mis_pc", pc, 32'h0000_3102);
`ifdef PC_FETCH_FAULT_CHECK_EN
    chk("mis_fault", b2w(fetch_fault), 32'd1);
    im_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("mis_req_low", b2w(im_req), 32'd0);
      step();
    end
    chk("mis_cnt_frozen", fetch_cnt, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; im_rdata = 32'hDDDD_0000;
    step();
    step();
    im_ack = 1'b0;
    load(32'h0000_2FFC);
    chk("low_fault", b2w(fetch_fault), 32'd1);
    chk("low_pc", pc, 32'h0000_2FFC);
    chk("low_req", b2w(im_req), 32'd0);
`else
    chk("mis_addr", a2w(im_addr), 32'h40);
    chk("mis_req", b2w(im_req), 32'd1);
    chk("mis_fault", b2w(fetch_fault), 32'd0);
    im_ack = 1'b1; im_rdata = 32'hEEEE_0040;
    step();
    chk("mis_cnt", fetch_cnt, 32'd2);
    im_ack = 1'b0;
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential counterpart of the next-PC selector: holds the architectural PC, consumes the selected npc, and fetches the instruction at PC from a handshaked instruction memory.
- Presents `instr`/`instr_valid` to decode, then waits for the core to commit the current instruction via `npc_load` before fetching the next one.
- Sits between the next-PC mux (its `pc` output feeds the mux; the mux's `npc` feeds back) and the IM.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address mapped to IM word 0.
- IM_AW, 12, IM word-address width; IM depth is 2^IM_AW words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from the next-PC selector.
- npc_load  in  1  core has committed the current instruction; load npc.
- pc  out  32  current PC.
- im_req  out  1  IM read request.
- im_addr  out  IM_AW  IM word address.
- im_ack  in  1  IM response; im_rdata valid in the same cycle.
- im_rdata  in  32  IM read data.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr holds the word at pc.
- fetch_cnt  out  32  completed fetches since reset.
- fetch_fault  out  1  fault flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (rst_n=0, async):
  - pc=PC_RESET, instr=0, instr_valid=0, fetch_cnt=0, fetch_fault=0, state=S_IDLE.
  - im_req=0 while in reset.
- FSM S_IDLE -> S_REQ -> S_HOLD -> S_REQ ..., plus S_FAULT (optional feature only).
- S_IDLE:
  - Lasts exactly one cycle after reset release.
  - im_req=0; unconditionally go to S_REQ.
- S_REQ:
  - im_req=1 combinationally; im_addr=(pc-IM_BASE)[IM_AW+1:2], 32-bit modulo subtraction.
  - im_req stays high and im_addr stays stable until im_ack is sampled high.
  - im_ack may arrive in the first S_REQ cycle (zero-wait) or any later cycle.
  - On the im_ack edge: instr<=im_rdata, instr_valid<=1, fetch_cnt<=fetch_cnt+1 (wraps at 2^32), go to S_HOLD.
  - npc_load in S_REQ is ignored; pc does not change.
- S_HOLD:
  - im_req=0; instr and instr_valid=1 stay stable.
  - On npc_load: pc<=npc, instr_valid<=0, go to S_REQ.
  - Minimum committed-instruction period is therefore 2 cycles with a zero-wait IM.
- im_ack outside S_REQ is ignored.
- npc low 2 bits:
  - Without the optional feature, they are loaded into pc unchanged.
  - im_addr drops them; the IM word index wraps modulo 2^IM_AW.
- Async reset mid-fetch (S_REQ with im_req high) aborts the fetch: im_req drops immediately, and the IM must discard the pending request.
- No combinational path from im_rdata/im_ack to any output; instr is registered.

Optional Feature:
- Macro: PC_FETCH_FAULT_CHECK_EN
- Defined:
  - On npc_load in S_HOLD, check npc[1:0]!=0, npc<IM_BASE, and npc-IM_BASE>=2^(IM_AW+2).
  - On any violation: pc<=npc, instr<=0 (nop), instr_valid<=0, fetch_fault<=1, go to S_FAULT.
  - The same range check applies to PC_RESET when leaving S_IDLE.
  - S_FAULT: im_req=0, all outputs frozen, exit only via reset.
- Undefined: no checks; fetch_fault constant 0; S_FAULT unreachable and not synthesized.

Test Plan:
- Reset then zero-wait IM (im_ack=1 in the first req cycle, im_rdata=32'h2408_0001):
  - im_req rises exactly 1 cycle after rst_n release with im_addr=0.
  - Next edge: instr=32'h2408_0001, instr_valid=1, fetch_cnt=1, pc=32'h0000_3000.
- Wait states: im_ack delayed 3 cycles:
  - im_req held high 4 cycles with im_addr stable.
  - instr_valid rises only after the ack edge.
- Sequential stream: npc_load with npc=pc+4 five times:
  - pc 0x3000 -> 0x3014.
  - im_addr 0,1,2,3,4,5.
  - fetch_cnt=6.
  - instr_valid low exactly in each S_REQ cycle.
- Branch/jump: in S_HOLD, npc=32'h0000_3100 with npc_load:
  - pc=0x3100, next im_addr=0x40.
  - npc_load pulsed during S_REQ is ignored, with no pc change.
- Async reset mid-fetch: assert rst_n=0 while im_req=1 and before ack:
  - All outputs at reset values within the same cycle.
  - Fetch restarts at 0x3000 after release.
- With PC_FETCH_FAULT_CHECK_EN:
  - npc=32'h0000_3102 -> fetch_fault=1, im_req stays 0 for 10 cycles, pc=0x3102.
  - npc=32'h0000_2FFC also faults.
  - Without the macro, 0x3102 fetches im_addr=0x40.
